// File: rtl/keyed_dupe_pkg.sv
// rtl/keyed_dupe_pkg.sv - shared state encodings and legality check for keyed_dupe_seq
package keyed_dupe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHK   = 3'd3,
    ST_CHK_D = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Codes 6 and 7 are unused and must recover to IDLE.
  function automatic logic is_legal(input logic [2:0] s);
    return (s <= 3'd5);
  endfunction

endpackage

// File: rtl/keyed_dupe_if.sv
// rtl/keyed_dupe_if.sv - control/status bundle for keyed_dupe_seq (tamper_o under KEYED_DUPE_TAMPER_FLAG_EN)
interface keyed_dupe_if #(
  parameter int KEY_W = 8
);
  logic             start;
  logic             step;
  logic             ack;
  logic [KEY_W-1:0] key;
  logic             busy_o;
  logic             load_o;
  logic             beat_o;
  logic             done_o;
  logic [2:0]       state_o;
`ifdef KEYED_DUPE_TAMPER_FLAG_EN
  logic             tamper_o;
`endif

  modport master (
    output start, step, ack, key,
`ifdef KEYED_DUPE_TAMPER_FLAG_EN
    input  tamper_o,
`endif
    input  busy_o, load_o, beat_o, done_o, state_o
  );

  modport slave (
    input  start, step, ack, key,
`ifdef KEYED_DUPE_TAMPER_FLAG_EN
    output tamper_o,
`endif
    output busy_o, load_o, beat_o, done_o, state_o
  );

endinterface

// File: rtl/keyed_route_cnt.sv
// rtl/keyed_route_cnt.sv - key comparator plus saturating decoy-visit counter
module keyed_route_cnt #(
  parameter int               KEY_W   = 8,
  parameter logic [KEY_W-1:0] KEY_VAL = KEY_W'(8'hA5),
  parameter int               THRESH  = 5,
  parameter int               CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_inc,
  output logic             o_key_ok,
  output logic             o_corrupt
);

  logic [CNT_W-1:0] r_cnt;

  assign o_key_ok  = (i_key == KEY_VAL);
  assign o_corrupt = (r_cnt >= CNT_W'(THRESH - 1));

  // Counts every acknowledged decoy exit; parks at THRESH once corruption starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < CNT_W'(THRESH))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keyed_dupe_seq.sv
// rtl/keyed_dupe_seq.sv - keyed duplicated-state run sequencer; optional tamper_o via KEYED_DUPE_TAMPER_FLAG_EN
module keyed_dupe_seq
  import keyed_dupe_pkg::*;
#(
  parameter int               KEY_W   = 8,
  parameter logic [KEY_W-1:0] KEY_VAL = KEY_W'(8'hA5),
  parameter int               LEN     = 4,
  parameter int               THRESH  = 5,
  parameter int               CNT_W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  keyed_dupe_if.slave  bus
);

  localparam int LEN_W = (LEN > 1) ? $clog2(LEN) : 1;

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_beat_cnt;
  logic             w_legal;
  logic             w_key_ok;
  logic             w_corrupt;
  logic             w_decoy_inc;

  assign w_legal     = is_legal(r_state);
  assign w_decoy_inc = (r_state == ST_CHK_D) && bus.ack;

  keyed_route_cnt #(
    .KEY_W  (KEY_W),
    .KEY_VAL(KEY_VAL),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) u_route (
    .clk      (clk),
    .rst      (rst),
    .i_key    (bus.key),
    .i_inc    (w_decoy_inc),
    .o_key_ok (w_key_ok),
    .o_corrupt(w_corrupt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_beat_cnt <= '0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.step) begin
            if (r_beat_cnt == LEN_W'(LEN - 1)) begin
              r_beat_cnt <= '0;
              r_state    <= w_key_ok ? ST_CHK : ST_CHK_D;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_CHK:   if (bus.ack) r_state <= ST_DONE;
        // The decoy looks genuine until its counter crosses the threshold.
        ST_CHK_D: if (bus.ack) r_state <= w_corrupt ? ST_LOAD : ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o  = w_legal && (r_state != ST_IDLE);
  assign bus.load_o  = (r_state == ST_LOAD);
  assign bus.beat_o  = (r_state == ST_RUN) && bus.step;
  assign bus.done_o  = bus.ack && ((r_state == ST_CHK) ||
                                   ((r_state == ST_CHK_D) && !w_corrupt));
  assign bus.state_o = w_legal ? r_state : 3'd0;

`ifdef KEYED_DUPE_TAMPER_FLAG_EN
  logic r_tamper;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tamper <= 1'b0;
    end else if (w_decoy_inc && w_corrupt) begin
      r_tamper <= 1'b1;
    end
  end

  assign bus.tamper_o = r_tamper;
`endif

endmodule
